// File: rtl/exe_mem_elastic_stage_if.sv
// EXE->MEM handshake bundle: upstream entry fields plus the registered head entry.
// Latency: none, this is wiring only.
// Backpressure: in_ready from the stage, out_ready from the MEM consumer.
interface exe_mem_elastic_stage_if #(
  parameter int ASIZE  = 5,
  parameter int DSIZE  = 16,
  parameter int ISIZE  = 16,
  parameter int CTRL_W = 4
);
  // Upstream (EXE) side
  logic              in_valid;
  logic              in_ready;
  logic [ASIZE-1:0]  in_w_addr;
  logic [DSIZE-1:0]  in_w_data;
  logic [DSIZE-1:0]  in_rdata2;
  logic [CTRL_W-1:0] in_ctrl;
  logic [ISIZE-1:0]  in_pc;

  // Downstream (MEM) side
  logic              out_valid;
  logic              out_ready;
  logic [ASIZE-1:0]  out_w_addr;
  logic [DSIZE-1:0]  out_w_data;
  logic [DSIZE-1:0]  out_rdata2;
  logic [CTRL_W-1:0] out_ctrl;
  logic [ISIZE-1:0]  out_pc;

  // Environment view: produces entries for the stage and consumes its head.
  modport master (
    output in_valid, in_w_addr, in_w_data, in_rdata2, in_ctrl, in_pc, out_ready,
    input  in_ready, out_valid, out_w_addr, out_w_data, out_rdata2, out_ctrl, out_pc
  );

  // Stage view.
  modport slave (
    input  in_valid, in_w_addr, in_w_data, in_rdata2, in_ctrl, in_pc, out_ready,
    output in_ready, out_valid, out_w_addr, out_w_data, out_rdata2, out_ctrl, out_pc
  );
endinterface

// File: rtl/exe_mem_elastic_stage.sv
// EXE->MEM elastic pipeline register with 2-entry skid buffer, flush and perf counters.
// Latency: 1 cycle from EMPTY; throughput 1 entry/cycle while out_ready=1.
// Backpressure: absorbs one extra entry into skid after out_ready drops; in_ready is registered.
module exe_mem_elastic_stage #(
  parameter int ASIZE  = 5,
  parameter int DSIZE  = 16,
  parameter int ISIZE  = 16,
  parameter int CTRL_W = 4,
  parameter int CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  exe_mem_elastic_stage_if.slave        bus,
  output logic [CNT_W-1:0]              stall_cnt,
  output logic [CNT_W-1:0]              bubble_cnt
);

  // One pipeline entry; ctrl order is {wen, memToReg, memRead, memWrite}.
  typedef struct packed {
    logic [ASIZE-1:0]  w_addr;
    logic [DSIZE-1:0]  w_data;
    logic [DSIZE-1:0]  rdata2;
    logic [CTRL_W-1:0] ctrl;
    logic [ISIZE-1:0]  pc;
  } entry_t;

  // Encoding is {skid_valid, main_valid} so the valid bits fall straight out of the state.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t state;
  entry_t main_q;
  entry_t skid_q;
  entry_t in_entry;

  logic main_valid;
  logic skid_valid;
  logic in_fire;
  logic out_fire;

  assign main_valid = state[0];
  assign skid_valid = state[1];

  // in_ready comes only from registered state, so there is no out_ready -> in_ready path.
  assign bus.in_ready = ~skid_valid;
  assign in_fire      = bus.in_valid & ~skid_valid;
  assign out_fire     = main_valid & bus.out_ready;

  assign in_entry.w_addr = bus.in_w_addr;
  assign in_entry.w_data = bus.in_w_data;
  assign in_entry.rdata2 = bus.in_rdata2;
  assign in_entry.ctrl   = bus.in_ctrl;
  assign in_entry.pc     = bus.in_pc;

  // Head entry drives the MEM side; stale payload is harmless because ctrl is gated.
  assign bus.out_valid  = main_valid;
  assign bus.out_w_addr = main_q.w_addr;
  assign bus.out_w_data = main_q.w_data;
  assign bus.out_rdata2 = main_q.rdata2;
  assign bus.out_pc     = main_q.pc;
  // A bubble must never assert memWrite or wen downstream.
  assign bus.out_ctrl   = main_valid ? main_q.ctrl : '0;

  // Occupancy FSM and payload moves; flush drops everything, including a same-cycle accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            main_q <= in_entry;
            state  <= ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_entry;
          end else if (out_fire) begin
            state <= EMPTY;
          end else if (in_fire) begin
            skid_q <= in_entry;
            state  <= FULL;
          end
        end
        FULL: begin
          // in_ready is low here, so only the drain of main can happen.
          if (out_fire) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Saturating perf counters from the pre-flush handshake; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      if (main_valid && !bus.out_ready && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      if (!main_valid && bus.out_ready && (bubble_cnt != {CNT_W{1'b1}}))
        bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_exe_mem_elastic_stage.sv
// Self-checking bench: directed table, hand sequences and a randomized queue-model run.
module tb_exe_mem_elastic_stage;

  typedef struct packed {
    logic [4:0]  w_addr;
    logic [15:0] w_data;
    logic [15:0] rdata2;
    logic [3:0]  ctrl;
    logic [15:0] pc;
  } ent_t;

  typedef struct {
    bit          iv;
    bit          rdy;
    bit          fl;
    logic [15:0] pc;
    logic [3:0]  ctrl;
    bit          e_ov;
    bit          e_ir;
    logic [15:0] e_pc;
    logic [3:0]  e_ctrl;
    int          e_st;
    int          e_bu;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic flush_s = 1'b0;
  logic [15:0] stall_cnt, bubble_cnt;
  logic [2:0]  stall_s, bubble_s;

  int checks = 0;
  int errors = 0;

  exe_mem_elastic_stage_if #(.ASIZE(5), .DSIZE(16), .ISIZE(16), .CTRL_W(4)) b ();
  exe_mem_elastic_stage_if #(.ASIZE(5), .DSIZE(16), .ISIZE(16), .CTRL_W(4)) s ();

  exe_mem_elastic_stage #(.ASIZE(5), .DSIZE(16), .ISIZE(16), .CTRL_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(b),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  exe_mem_elastic_stage #(.ASIZE(5), .DSIZE(16), .ISIZE(16), .CTRL_W(4), .CNT_W(3)) dut_sat (
    .clk(clk), .rst(rst), .flush(flush_s), .bus(s),
    .stall_cnt(stall_s), .bubble_cnt(bubble_s)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered queue of at most two entries plus plain counters.
  ent_t mq[$];
  int   m_stall = 0;
  int   m_bubble = 0;
  bit   held = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic ent_t cur_in();
    ent_t e;
    e.w_addr = b.in_w_addr;
    e.w_data = b.in_w_data;
    e.rdata2 = b.in_rdata2;
    e.ctrl   = b.in_ctrl;
    e.pc     = b.in_pc;
    return e;
  endfunction

  task automatic model_step();
    bit ov;
    bit ir;
    ov = (mq.size() > 0);
    ir = (mq.size() < 2);
    held = b.in_valid && !ir;
    if (rst) begin
      mq.delete();
      m_stall = 0;
      m_bubble = 0;
    end else begin
      if (ov && !b.out_ready && m_stall < 65535) m_stall++;
      if (!ov && b.out_ready && m_bubble < 65535) m_bubble++;
      if (flush) mq.delete();
      else begin
        if (ov && b.out_ready) void'(mq.pop_front());
        if (b.in_valid && ir) mq.push_back(cur_in());
      end
    end
  endtask

  task automatic model_check();
    chk("out_valid", {31'd0, b.out_valid}, {31'd0, mq.size() > 0});
    chk("in_ready", {31'd0, b.in_ready}, {31'd0, mq.size() < 2});
    if (mq.size() > 0) begin
      chk("out_pc", {16'd0, b.out_pc}, {16'd0, mq[0].pc});
      chk("out_w_addr", {27'd0, b.out_w_addr}, {27'd0, mq[0].w_addr});
      chk("out_w_data", {16'd0, b.out_w_data}, {16'd0, mq[0].w_data});
      chk("out_rdata2", {16'd0, b.out_rdata2}, {16'd0, mq[0].rdata2});
      chk("out_ctrl", {28'd0, b.out_ctrl}, {28'd0, mq[0].ctrl});
    end else begin
      chk("out_ctrl_gated", {28'd0, b.out_ctrl}, 32'd0);
    end
    chk("stall_cnt", {16'd0, stall_cnt}, m_stall);
    chk("bubble_cnt", {16'd0, bubble_cnt}, m_bubble);
  endtask

  // Inputs change at negedge; model advances at posedge; outputs compared at next negedge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
  endtask

  task automatic drive(input bit iv, input bit rdy, input bit fl,
                       input logic [15:0] pc, input logic [3:0] ctrl);
    b.in_valid  = iv;
    b.out_ready = rdy;
    flush       = fl;
    b.in_pc     = pc;
    b.in_ctrl   = ctrl;
    b.in_w_addr = pc[4:0] ^ 5'h15;
    b.in_w_data = pc ^ 16'hA5A5;
    b.in_rdata2 = ~pc;
  endtask

  vec_t vt[13];

  initial begin
    // Directed skid / flush / bubble table (hand-derived expectations after each edge).
    vt[0]  = '{1, 1, 0, 16'd0,  4'hF, 1, 1, 16'd0,  4'hF, 0, 1};
    vt[1]  = '{1, 1, 0, 16'd1,  4'hF, 1, 1, 16'd1,  4'hF, 0, 1};
    vt[2]  = '{1, 0, 0, 16'd2,  4'hF, 1, 0, 16'd1,  4'hF, 1, 1};
    vt[3]  = '{1, 0, 0, 16'd3,  4'hF, 1, 0, 16'd1,  4'hF, 2, 1};
    vt[4]  = '{1, 0, 0, 16'd3,  4'hF, 1, 0, 16'd1,  4'hF, 3, 1};
    vt[5]  = '{1, 1, 0, 16'd3,  4'hF, 1, 1, 16'd2,  4'hF, 3, 1};
    vt[6]  = '{1, 1, 0, 16'd3,  4'hF, 1, 1, 16'd3,  4'hF, 3, 1};
    vt[7]  = '{0, 1, 0, 16'd0,  4'hF, 0, 1, 16'd0,  4'h0, 3, 1};
    vt[8]  = '{1, 0, 0, 16'd8,  4'h1, 1, 1, 16'd8,  4'h1, 3, 1};
    vt[9]  = '{1, 0, 0, 16'd9,  4'h1, 1, 0, 16'd8,  4'h1, 4, 1};
    vt[10] = '{1, 0, 1, 16'd10, 4'h1, 0, 1, 16'd0,  4'h0, 5, 1};
    vt[11] = '{0, 0, 0, 16'd0,  4'h1, 0, 1, 16'd0,  4'h0, 5, 1};
    vt[12] = '{1, 1, 0, 16'd12, 4'hF, 1, 1, 16'd12, 4'hF, 5, 2};

    s.in_valid = 1'b0; s.out_ready = 1'b0; s.in_pc = '0; s.in_ctrl = '0;
    s.in_w_addr = '0; s.in_w_data = '0; s.in_rdata2 = '0;

    // Reset held two cycles with live, random upstream traffic.
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'($urandom), 1'($urandom), 16'($urandom), 4'($urandom));
      cycle();
      chk("rst_out_valid", {31'd0, b.out_valid}, 32'd0);
      chk("rst_in_ready", {31'd0, b.in_ready}, 32'd1);
      chk("rst_out_ctrl", {28'd0, b.out_ctrl}, 32'd0);
      chk("rst_out_pc", {16'd0, b.out_pc}, 32'd0);
      chk("rst_out_w_addr", {27'd0, b.out_w_addr}, 32'd0);
      chk("rst_out_w_data", {16'd0, b.out_w_data}, 32'd0);
      chk("rst_out_rdata2", {16'd0, b.out_rdata2}, 32'd0);
      chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
      chk("rst_bubble", {16'd0, bubble_cnt}, 32'd0);
    end
    rst = 1'b0;

    // First entry is visible one edge after acceptance.
    drive(1'b1, 1'b0, 1'b0, 16'h0055, 4'h3);
    cycle();
    chk("latency_valid", {31'd0, b.out_valid}, 32'd1);
    chk("latency_pc", {16'd0, b.out_pc}, 32'h55);

    drive(1'b0, 1'b0, 1'b0, 16'd0, 4'd0);
    rst = 1'b1; cycle(); rst = 1'b0;

    // Streaming: 8 back-to-back entries, 1-cycle latency, never stalls.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b1, 1'b0, 16'(i), 4'hF);
      cycle();
      chk("stream_pc", {16'd0, b.out_pc}, i);
      chk("stream_in_ready", {31'd0, b.in_ready}, 32'd1);
      chk("stream_stall", {16'd0, stall_cnt}, 32'd0);
    end

    drive(1'b0, 1'b0, 1'b0, 16'd0, 4'd0);
    rst = 1'b1; cycle(); rst = 1'b0;

    // Table: skid absorb, drain in order, flush in FULL with concurrent memWrite entry.
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].iv, vt[i].rdy, vt[i].fl, vt[i].pc, vt[i].ctrl);
      cycle();
      chk($sformatf("vec%0d_out_valid", i), {31'd0, b.out_valid}, {31'd0, vt[i].e_ov});
      chk($sformatf("vec%0d_in_ready", i), {31'd0, b.in_ready}, {31'd0, vt[i].e_ir});
      chk($sformatf("vec%0d_out_ctrl", i), {28'd0, b.out_ctrl}, {28'd0, vt[i].e_ctrl});
      if (vt[i].e_ov)
        chk($sformatf("vec%0d_out_pc", i), {16'd0, b.out_pc}, {16'd0, vt[i].e_pc});
      chk($sformatf("vec%0d_stall", i), {16'd0, stall_cnt}, vt[i].e_st);
      chk($sformatf("vec%0d_bubble", i), {16'd0, bubble_cnt}, vt[i].e_bu);
    end

    // Bubble gating: consume the ctrl=1111 head, then 5 idle cycles with out_ready=1.
    drive(1'b0, 1'b1, 1'b0, 16'd0, 4'hF);
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bubble_ctrl_zero", {28'd0, b.out_ctrl}, 32'd0);
    end
    chk("bubble_plus5", {16'd0, bubble_cnt}, 32'd7);

    // Randomized traffic against the queue model, honouring the hold-until-accepted rule.
    for (int n = 0; n < 600; n++) begin
      if (held) begin
        b.out_ready = 1'($urandom_range(0, 3) != 0);
        flush       = 1'($urandom_range(0, 19) == 0);
      end else begin
        drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
              1'($urandom_range(0, 19) == 0), 16'($urandom), 4'($urandom));
      end
      rst = 1'($urandom_range(0, 99) == 0);
      cycle();
    end
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 16'd0, 4'd0);
    rst = 1'b1; cycle(); rst = 1'b0;

    // Saturation on the 3-bit counter instance.
    s.in_valid = 1'b1; s.in_pc = 16'h0077; s.in_ctrl = 4'h1;
    cycle();
    s.in_valid = 1'b0;
    chk("sat_accept", {31'd0, s.out_valid}, 32'd1);
    for (int k = 1; k <= 10; k++) begin
      cycle();
      chk("sat_stall", {29'd0, stall_s}, (k < 7) ? k : 7);
    end
    flush_s = 1'b1;
    cycle();
    flush_s = 1'b0;
    chk("sat_after_flush", {29'd0, stall_s}, 32'd7);
    chk("sat_flush_valid", {31'd0, s.out_valid}, 32'd0);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("sat_after_rst", {29'd0, stall_s}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/exe_mem_elastic_stage.md
# exe_mem_elastic_stage

Parametrised elastic pipeline register for the EXE→MEM boundary of the five-stage CPU. Carries the ALU result, store data, write-back address, PC and memory/write-back control bits with a valid/ready handshake, a two-entry skid buffer and a synchronous flush. Control bits are gated so that a bubble never causes a memory write or register write-back. Saturating stall and bubble counters provide pipeline performance visibility.

## Interface
Parameters:
- ASIZE, 5: width of the register write-back address.
- DSIZE, 16: width of the ALU result and of the store data.
- ISIZE, 16: width of the PC.
- CTRL_W, 4: control bit count; bit order {wen, memToReg, memRead, memWrite}, bit 0 = memWrite.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all held entries this cycle.
- in_valid  in  1  EXE presents a valid entry.
- in_ready  out  1  stage can accept; equals NOT skid_valid.
- in_w_addr  in  ASIZE  write-back register address.
- in_w_data  in  DSIZE  ALU result.
- in_rdata2  in  DSIZE  store data.
- in_ctrl  in  CTRL_W  control bits.
- in_pc  in  ISIZE  PC of the instruction.
- out_valid  out  1  MEM side holds a valid entry.
- out_ready  in  1  MEM consumes the entry this cycle.
- out_w_addr, out_w_data, out_rdata2, out_pc  out  ASIZE/DSIZE/DSIZE/ISIZE  head-entry payload.
- out_ctrl  out  CTRL_W  head control; forced to 0 whenever out_valid=0.
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.
- bubble_cnt  out  CNT_W  cycles with out_valid=0 and out_ready=1.

## Operation
- Storage: a main register (drives the outputs) and a skid register, each with its own valid bit. Entry order is preserved.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States, encoded by {skid_valid, main_valid}:
  - EMPTY: in_fire → main←in, go to ONE.
  - ONE:
    - in_fire & out_fire → main←in, stay in ONE.
    - out_fire only → EMPTY.
    - in_fire only → skid←in, go to FULL.
    - neither → hold.
  - FULL: in_ready=0. out_fire → main←skid, go to ONE. Otherwise hold.
- Flush: highest priority after rst. Clears both valid bits, so the next state is EMPTY. Any in_fire in the same cycle is discarded. Payload registers may keep stale data. The counters still update from that cycle's pre-flush out_valid/out_ready.
- Payload registers are not cleared when an entry is consumed. Only valid and the gated out_ctrl indicate meaning.
- Counters: each increments by 1 per qualifying cycle and saturates at all-ones (no wrap). Only rst clears them; flush does not.
- in_valid with in_ready=0 is ignored. EXE must hold its entry until it is accepted.

## Timing
- Reset, on the first rising edge with rst=1: both valid bits 0, so out_valid=0 and in_ready=1. All payload outputs 0, out_ctrl=0, stall_cnt=0, bubble_cnt=0. rst overrides flush and all handshakes.
- Latency: an entry accepted at edge N is visible on the outputs after edge N, i.e. 1 cycle from EMPTY.
- Throughput: 1 entry/cycle while out_ready=1.
- in_ready depends only on registered state, with no combinational path from out_ready. out_valid and out_* are registered.
- Backpressure: when out_ready drops, at most one more entry is absorbed into the skid register. in_ready falls on the following edge.
- Reset or flush mid-transfer: the entry is lost and it is not replayed. The upstream hazard unit is responsible for re-issue.

## Test plan
- Reset: hold rst 2 cycles with in_valid=1 and random inputs → out_valid=0, in_ready=1, out_ctrl=0, all outputs 0, counters 0. Release rst → first entry appears 1 cycle after acceptance.
- Streaming: out_ready=1, 8 back-to-back entries with in_pc=0x0000..0x0007 → out_pc sequence identical, 1-cycle latency, in_ready constantly 1, stall_cnt=0.
- Skid: while streaming, drop out_ready for 3 cycles → exactly one extra entry accepted, then in_ready=0. stall_cnt=3. Release → no loss, no duplication, order preserved.
- Flush in FULL with simultaneous in_valid=1, ctrl=4'b0001 → next cycle out_valid=0, out_ctrl=0 (no memWrite pulse), in_ready=1. The flushed entries and the simultaneous entry never appear.
- Bubble gating: in_valid=0, out_ready=1 for 5 cycles after an entry with ctrl=4'b1111 was consumed → out_ctrl=0 throughout, bubble_cnt increments by 5.
- Saturation: CNT_W=3, out_valid=1, out_ready=0 for 10 cycles → stall_cnt reaches 7 and stays 7. A following flush leaves it at 7; rst clears it to 0.
